// File: rtl/tn_timer_pkg.sv
// Shared constants and byte-merge helper for the tn_wb_timer Wishbone machine timer.
package tn_timer_pkg;

    localparam logic [1:0] TN_TIMER_MTIME    = 2'd0;
    localparam logic [1:0] TN_TIMER_MTIMECMP = 2'd1;
    localparam logic [1:0] TN_TIMER_CTRL     = 2'd2;
    localparam logic [1:0] TN_TIMER_PRESCALE = 2'd3;

    localparam int TN_TIMER_CTRL_EN = 0;
    localparam int TN_TIMER_CTRL_IE = 1;

    localparam logic [31:0] TN_TIMER_CMP_RST = 32'hFFFF_FFFF;

    function automatic logic [31:0] tn_timer_merge(input logic [31:0] old_word,
                                                   input logic [31:0] wr_dat,
                                                   input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = sel[b] ? wr_dat[8*b +: 8] : old_word[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/tn_timer_prescaler.sv
// Reloadable down-counter that issues one tick every reload_val+1 enabled cycles.
module tn_timer_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [PRESCALE_W-1:0] i_reload_val,
    input  logic                  i_reload,
    output logic                  o_tick
);

    logic [PRESCALE_W-1:0] cnt;

    assign o_tick = i_en && (cnt == '0);

    always_ff @(posedge clk) begin
        if (i_rst)
            cnt <= '0;
        else if (i_reload)
            cnt <= i_reload_val;
        else if (i_en)
            cnt <= (cnt == '0) ? i_reload_val : cnt - 1'b1;
    end

endmodule

// File: rtl/tn_wb_timer.sv
// Wishbone-slave machine timer: mtime/mtimecmp/CTRL/PRESCALE and a level irq.
// Optional prescaler is built when TN_TIMER_PRESCALER_EN is defined.
module tn_wb_timer
    import tn_timer_pkg::*;
#(
    parameter int PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [3:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_timer_irq
);

    logic [31:0] mtime;
    logic [31:0] mtimecmp;
    logic [1:0]  ctrl;
    logic [31:0] rd_word;
    logic [31:0] wr_word;
    logic [31:0] pre_word;
    logic [1:0]  idx;
    logic        wb_req;
    logic        wr_en;
    logic        tick;
    logic        unused_adr;

    assign idx        = i_wb_adr[3:2];
    assign wb_req     = i_wb_cyc && !o_wb_ack;
    assign wr_en      = wb_req && i_wb_we;
    assign unused_adr = ^i_wb_adr[1:0];

`ifdef TN_TIMER_PRESCALER_EN
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pre_rld;
    logic                  wr_pre;

    assign pre_word = 32'(prescale);
    assign wr_pre   = wr_en && (idx == TN_TIMER_PRESCALE);
    // A PRESCALE write reloads the down-counter with the new value, not the stale one.
    assign pre_rld  = wr_pre ? wr_word[PRESCALE_W-1:0] : prescale;

    tn_timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_en         (ctrl[TN_TIMER_CTRL_EN]),
        .i_reload_val (pre_rld),
        .i_reload     (wr_pre),
        .o_tick       (tick)
    );
`else
    localparam int unused_prescale_w = PRESCALE_W;
    assign pre_word = 32'h0;
    assign tick     = 1'b1;
`endif

    always_comb begin
        rd_word = 32'h0;
        case (idx)
            TN_TIMER_MTIME:    rd_word = mtime;
            TN_TIMER_MTIMECMP: rd_word = mtimecmp;
            TN_TIMER_CTRL:     rd_word = {30'h0, ctrl};
            TN_TIMER_PRESCALE: rd_word = pre_word;
            default:           rd_word = 32'h0;
        endcase
    end

    assign wr_word = tn_timer_merge(rd_word, i_wb_dat, i_wb_sel);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            mtime       <= 32'h0;
            mtimecmp    <= TN_TIMER_CMP_RST;
            ctrl        <= 2'b00;
            o_wb_ack    <= 1'b0;
            o_wb_rdt    <= 32'h0;
            o_timer_irq <= 1'b0;
`ifdef TN_TIMER_PRESCALER_EN
            prescale    <= '0;
`endif
        end else begin
            o_wb_ack <= wb_req;
            if (wb_req)
                o_wb_rdt <= rd_word;

            // A bus write to MTIME overrides the increment on the same edge.
            if (wr_en && idx == TN_TIMER_MTIME)
                mtime <= wr_word;
            else if (ctrl[TN_TIMER_CTRL_EN] && tick)
                mtime <= mtime + 32'd1;

            if (wr_en && idx == TN_TIMER_MTIMECMP)
                mtimecmp <= wr_word;
            if (wr_en && idx == TN_TIMER_CTRL)
                ctrl <= wr_word[1:0];
`ifdef TN_TIMER_PRESCALER_EN
            if (wr_pre)
                prescale <= wr_word[PRESCALE_W-1:0];
`endif

            o_timer_irq <= ctrl[TN_TIMER_CTRL_IE] && (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_tn_wb_timer.sv
// Directed bench for tn_wb_timer: register-map vector table plus irq, wrap, byte-write and reset sequences.
module tb_tn_wb_timer;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [3:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic        o_timer_irq;

    int   n_vec = 0;
    int   n_err = 0;
    logic irq_at_ack;

    always #5 clk = ~clk;

    tn_wb_timer #(.PRESCALE_W(8)) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_wb_adr    (i_wb_adr),
        .i_wb_dat    (i_wb_dat),
        .i_wb_sel    (i_wb_sel),
        .i_wb_we     (i_wb_we),
        .i_wb_cyc    (i_wb_cyc),
        .o_wb_rdt    (o_wb_rdt),
        .o_wb_ack    (o_wb_ack),
        .o_timer_irq (o_timer_irq)
    );

    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
        string       name;
    } vec_t;

`ifdef TN_TIMER_PRESCALER_EN
    localparam logic [31:0] PRE_RD = 32'h0000_00FF;
`else
    localparam logic [31:0] PRE_RD = 32'h0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus access; returns once ack has dropped again.
    task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdt);
        bit got = 0;
        rdt = 32'h0;
        @(negedge clk);
        i_wb_cyc = 1'b1; i_wb_we = we; i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (o_wb_ack) begin
                got = 1; rdt = o_wb_rdt; irq_at_ack = o_timer_irq;
            end
        end
        i_wb_cyc = 1'b0; i_wb_we = 1'b0;
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL bus_timeout: got no ack, expected ack within 8 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] dat);
        logic [31:0] d;
        wb_xfer(1'b1, adr, dat, 4'hF, d);
    endtask

    task automatic rd(input logic [3:0] adr, output logic [31:0] d);
        wb_xfer(1'b0, adr, 32'h0, 4'h0, d);
    endtask

    vec_t        vecs[16];
    logic [31:0] r, r1;

    initial begin
        vecs[0]  = '{1'b0, 4'h0, 32'h0,          4'h0, 32'h0000_0000, "rst_mtime"};
        vecs[1]  = '{1'b0, 4'h4, 32'h0,          4'h0, 32'hFFFF_FFFF, "rst_mtimecmp"};
        vecs[2]  = '{1'b0, 4'h8, 32'h0,          4'h0, 32'h0000_0000, "rst_ctrl"};
        vecs[3]  = '{1'b0, 4'hC, 32'h0,          4'h0, 32'h0000_0000, "rst_prescale"};
        vecs[4]  = '{1'b1, 4'h4, 32'h1234_5678,  4'hF, 32'h0,         "wr_cmp"};
        vecs[5]  = '{1'b0, 4'h4, 32'h0,          4'h0, 32'h1234_5678, "rd_cmp"};
        vecs[6]  = '{1'b1, 4'h4, 32'hAABB_CCDD,  4'h5, 32'h0,         "wr_cmp_sel"};
        vecs[7]  = '{1'b0, 4'h5, 32'h0,          4'h0, 32'h12BB_56DD, "rd_cmp_sel_lowadr"};
        vecs[8]  = '{1'b1, 4'h8, 32'hFFFF_FFFC,  4'hF, 32'h0,         "wr_ctrl_hi"};
        vecs[9]  = '{1'b0, 4'h8, 32'h0,          4'h0, 32'h0000_0000, "rd_ctrl_hi"};
        vecs[10] = '{1'b1, 4'h8, 32'h0000_0002,  4'hF, 32'h0,         "wr_ctrl_ie"};
        vecs[11] = '{1'b0, 4'h8, 32'h0,          4'h0, 32'h0000_0002, "rd_ctrl_ie"};
        vecs[12] = '{1'b1, 4'hC, 32'h1234_56FF,  4'hF, 32'h0,         "wr_pre"};
        vecs[13] = '{1'b0, 4'hC, 32'h0,          4'h0, PRE_RD,        "rd_pre"};
        vecs[14] = '{1'b1, 4'h0, 32'h0000_0007,  4'hF, 32'h0,         "wr_mtime"};
        vecs[15] = '{1'b0, 4'h0, 32'h0,          4'h0, 32'h0000_0007, "rd_mtime_stopped"};

        i_rst = 1'b1; i_wb_cyc = 1'b0; i_wb_we = 1'b0;
        i_wb_adr = 4'h0; i_wb_dat = 32'h0; i_wb_sel = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'h0, o_wb_ack}, 32'h0);
        check("rst_irq", {31'h0, o_timer_irq}, 32'h0);
        check("rst_rdt", o_wb_rdt, 32'h0);
        @(negedge clk); i_rst = 1'b0;

        // cyc held high: ack every second cycle, one cycle wide
        @(negedge clk); i_wb_cyc = 1'b1; i_wb_adr = 4'h0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("ack_pattern", {31'h0, o_wb_ack}, (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        i_wb_cyc = 1'b0;

        for (int i = 0; i < 16; i++) begin
            wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, r);
            if (!vecs[i].we) check(vecs[i].name, r, vecs[i].exp);
        end
        wr(4'hC, 32'h0);
        wr(4'h8, 32'h0);
        wr(4'h0, 32'h0);

        // compare: mtime runs from 0, irq rises at the edge after mtime reaches 10
        wr(4'h4, 32'd10);
        wr(4'h8, 32'h3);
        repeat (9) @(posedge clk);
        #1;
        check("irq_before_cmp", {31'h0, o_timer_irq}, 32'h0);
        @(posedge clk); #1;
        check("irq_at_cmp", {31'h0, o_timer_irq}, 32'h1);
        rd(4'h0, r);
        check("mtime_at_irq", r, 32'd11);
        wr(4'h4, 32'd100);
        check("irq_during_cmp_wr", {31'h0, irq_at_ack}, 32'h1);
        check("irq_after_cmp_wr", {31'h0, o_timer_irq}, 32'h0);

        // wrap past 0xFFFFFFFF
        wr(4'h8, 32'h0);
        wr(4'h0, 32'hFFFF_FFFE);
        wr(4'h4, 32'hFFFF_FFFF);
        wr(4'h8, 32'h3);
        check("wrap_irq_pre", {31'h0, o_timer_irq}, 32'h0);
        @(posedge clk); #1;
        check("wrap_irq_hi", {31'h0, o_timer_irq}, 32'h1);
        @(posedge clk); #1;
        check("wrap_irq_lo", {31'h0, o_timer_irq}, 32'h0);
        rd(4'h0, r);
        check("wrap_mtime", r, 32'h1);

        // byte write to a running counter replaces the increment
        wr(4'h8, 32'h0);
        wr(4'h0, 32'h1122_3300);
        wr(4'h8, 32'h1);
        wb_xfer(1'b1, 4'h0, 32'h0000_0055, 4'h1, r);
        rd(4'h0, r);
        check("byte_wr_running", r, 32'h1122_3356);

`ifdef TN_TIMER_PRESCALER_EN
        wr(4'h8, 32'h0);
        wr(4'hC, 32'd3);
        wr(4'h0, 32'h0);
        wr(4'h8, 32'h1);
        rd(4'h0, r1);
        repeat (38) @(posedge clk);
        rd(4'h0, r);
        check("prescale_40cyc", r - r1, 32'd10);
        wr(4'hC, 32'h0);
`endif

        // reset lands on the ack edge of a CTRL write
        wr(4'h8, 32'h0);
        wr(4'h4, 32'h0);
        @(posedge clk); #1;
        i_wb_cyc = 1'b1; i_wb_we = 1'b1; i_wb_adr = 4'h8; i_wb_dat = 32'h3; i_wb_sel = 4'hF;
        @(negedge clk); i_rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_ack", {31'h0, o_wb_ack}, 32'h0);
        @(posedge clk); #1;
        check("rst_mid_ack2", {31'h0, o_wb_ack}, 32'h0);
        i_wb_cyc = 1'b0; i_wb_we = 1'b0;
        @(negedge clk); i_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_irq", {31'h0, o_timer_irq}, 32'h0);
        rd(4'h8, r);
        check("rst_mid_ctrl", r, 32'h0);
        rd(4'h4, r);
        check("rst_mid_cmp", r, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
